// File: rtl/jt12_multi_acc.sv
// Channel accumulator and L/R mixer for the FM operator pipeline.
// Each operator slot adds its carrier output into a per-channel running
// sum; on the S4 slot the channel total is panned/muted into the mix
// buses, and at the frame start the buses are saturated onto the outputs.
module jt12_multi_acc #(
  parameter int WIN    = 14,
  parameter int WOUT   = 16,
  parameter int CH     = 6,
  parameter int STEREO = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic signed [WIN-1:0]  op_result,
  input  logic                   s1_enters,
  input  logic                   s2_enters,
  input  logic                   s3_enters,
  input  logic                   s4_enters,
  input  logic                   zero,
  input  logic [2:0]             alg,
  input  logic                   pan_l,
  input  logic                   pan_r,
  input  logic [CH-1:0]          mute,
  input  logic                   ovf_clr,
  output logic signed [WOUT-1:0] snd_left,
  output logic signed [WOUT-1:0] snd_right,
  output logic                   sample,
  output logic                   ovf
);

  // Channel total: four WIN-bit operators need two guard bits.
  localparam int WA = WIN + 2;
  // Mix bus: CH channel totals need clog2(CH) more bits.
  localparam int WB = WA + $clog2(CH);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  // Comparison width wide enough for both the bus and the output range.
  localparam int WX = ((WB > WOUT) ? WB : WOUT) + 1;

  localparam logic signed [WX-1:0] SAT_MAX = {{(WX-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [WX-1:0] SAT_MIN = {{(WX-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  // Clamp a bus value into the output range.
  function automatic logic signed [WOUT-1:0] sat_val(input logic signed [WB-1:0] v);
    logic signed [WX-1:0] vx;
    vx = WX'(v);
    if (vx > SAT_MAX) return SAT_MAX[WOUT-1:0];
    if (vx < SAT_MIN) return SAT_MIN[WOUT-1:0];
    return vx[WOUT-1:0];
  endfunction

  // Report whether sat_val would have clamped this bus value.
  function automatic logic sat_hit(input logic signed [WB-1:0] v);
    logic signed [WX-1:0] vx;
    vx = WX'(v);
    return (vx > SAT_MAX) || (vx < SAT_MIN);
  endfunction

  logic [CW-1:0]          ch_cnt;
  logic [CW-1:0]          cur_ch;
  logic                   sum_en;
  logic signed [WA-1:0]   term_p0;
  logic signed [WA-1:0]   tot_p0;
  logic signed [WB-1:0]   tot_x_p0;
  logic signed [WA-1:0]   acc [CH];
  logic signed [WB-1:0]   mix_l_p1;
  logic signed [WB-1:0]   mix_r_p1;
  logic signed [WB-1:0]   bus_r_p1;
  logic                   primed;

  // ---- stage p0: slot decode and channel arithmetic ----

  // The zero slot is always channel 0, regardless of where the counter is.
  always_comb begin
    cur_ch = zero ? '0 : ch_cnt;
  end

  // Channel counter wraps CH-1 -> 0 and is realigned by the zero slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_cnt <= '0;
    end else if (clk_en) begin
      ch_cnt <= (cur_ch == CW'(CH-1)) ? '0 : cur_ch + 1'b1;
    end
  end

  // Carrier decode: which operator phases reach the output for this algorithm.
  always_comb begin
    sum_en = 1'b0;
    case (alg)
      3'd0, 3'd1, 3'd2, 3'd3: sum_en = s4_enters;
      3'd4:                   sum_en = s2_enters | s4_enters;
      3'd5, 3'd6:             sum_en = ~s1_enters;
      default:                sum_en = 1'b1;
    endcase
  end

  // Gated operator term and full-precision running total for this channel.
  always_comb begin
    term_p0  = sum_en ? WA'(op_result) : '0;
    tot_p0   = acc[cur_ch] + term_p0;
    tot_x_p0 = WB'(tot_p0);
  end

  // Per-channel accumulator: S1 restarts the sum, later phases add to it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else if (clk_en) begin
      if (s1_enters) begin
        acc[cur_ch] <= term_p0;
      end else if (s2_enters | s3_enters | s4_enters) begin
        acc[cur_ch] <= tot_p0;
      end
    end
  end

  // ---- stage p1: mix buses ----

  // Channel totals land on the buses at S4; the frame start empties them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mix_l_p1 <= '0;
      mix_r_p1 <= '0;
    end else if (clk_en) begin
      if (zero) begin
        mix_l_p1 <= '0;
        mix_r_p1 <= '0;
      end else if (s4_enters && !mute[cur_ch]) begin
        if (STEREO == 0 || pan_l) mix_l_p1 <= mix_l_p1 + tot_x_p0;
        if (STEREO != 0 && pan_r) mix_r_p1 <= mix_r_p1 + tot_x_p0;
      end
    end
  end

  // In mono builds the right output mirrors the left bus.
  always_comb begin
    bus_r_p1 = (STEREO != 0) ? mix_r_p1 : mix_l_p1;
  end

  // ---- stage p2: output latch, sample strobe and overflow ----

  // Outputs latch at the frame start; the first frame after reset is only
  // partial, so it primes the block without producing a sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      snd_left  <= '0;
      snd_right <= '0;
      sample    <= 1'b0;
      ovf       <= 1'b0;
      primed    <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (ovf_clr) ovf <= 1'b0;
      if (clk_en && zero) begin
        primed <= 1'b1;
        if (primed) begin
          snd_left  <= sat_val(mix_l_p1);
          snd_right <= sat_val(bus_r_p1);
          sample    <= 1'b1;
          if (sat_hit(mix_l_p1) || sat_hit(bus_r_p1)) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_multi_acc.sv
// Directed bench for jt12_multi_acc: a mono 3-channel instance and a
// stereo 6-channel instance share the slot stimulus.
module tb_jt12_multi_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clk_en, s1_enters, s2_enters, s3_enters, s4_enters;
  logic zero, pan_l, pan_r, ovf_clr;
  logic signed [13:0] op_result;
  logic [2:0] alg;
  logic [2:0] mute_m;
  logic [5:0] mute_s;
  logic signed [15:0] snd_left_m, snd_right_m, snd_left_s, snd_right_s;
  logic sample_m, ovf_m, sample_s, ovf_s;

  int checks = 0;
  int failures = 0;
  int pulses;
  bit opened = 0;
  bit gaps_on = 0;

  logic signed [13:0] op_tab [4][8];
  logic [2:0]         alg_tab [8];
  logic               pl_tab [8];
  logic               pr_tab [8];
  int                 alg_exp [8];

  jt12_multi_acc #(.WIN(14), .WOUT(16), .CH(3), .STEREO(0)) dut_m (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_result),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
    .s4_enters(s4_enters), .zero(zero), .alg(alg), .pan_l(pan_l), .pan_r(pan_r),
    .mute(mute_m), .ovf_clr(ovf_clr), .snd_left(snd_left_m), .snd_right(snd_right_m),
    .sample(sample_m), .ovf(ovf_m)
  );

  jt12_multi_acc #(.WIN(14), .WOUT(16), .CH(6), .STEREO(1)) dut_s (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_result),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters),
    .s4_enters(s4_enters), .zero(zero), .alg(alg), .pan_l(pan_l), .pan_r(pan_r),
    .mute(mute_s), .ovf_clr(ovf_clr), .snd_left(snd_left_s), .snd_right(snd_right_s),
    .sample(sample_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clk_en slot by linear frame index; optional clk_en=0 gaps before it
  // carry a bogus zero/op to show they are ignored.
  task automatic slot_at(input int nch, input int idx);
    int ph, c, ng;
    ph = idx / nch;
    c  = idx % nch;
    if (gaps_on) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        clk_en = 0; zero = 1; op_result = 14'sd1234;
        s1_enters = 1; s2_enters = 0; s3_enters = 0; s4_enters = 0;
        @(posedge clk); #1;
        check("gap_sample", (nch == 3) ? sample_m : sample_s, 0);
      end
    end
    zero = (idx == 0);
    s1_enters = (ph == 0); s3_enters = (ph == 1);
    s2_enters = (ph == 2); s4_enters = (ph == 3);
    op_result = op_tab[ph][c];
    alg = alg_tab[c]; pan_l = pl_tab[c]; pan_r = pr_tab[c];
    clk_en = 1;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int nch);
    pulses = 0;
    for (int i = (opened ? 1 : 0); i < 4*nch; i++) begin
      slot_at(nch, i);
      if (i > 0 && ((nch == 3) ? sample_m : sample_s) === 1'b1) pulses++;
    end
    opened = 0;
  endtask

  task automatic zero_slot(input int nch);
    slot_at(nch, 0);
    opened = 1;
  endtask

  task automatic measure(input int nch);
    run_frame(nch); zero_slot(nch);
    run_frame(nch); zero_slot(nch);
  endtask

  task automatic fill_tab(input logic signed [13:0] v, input logic [2:0] a);
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 8; c++) op_tab[p][c] = v;
    for (int c = 0; c < 8; c++) begin
      alg_tab[c] = a; pl_tab[c] = 1; pr_tab[c] = 1;
    end
  endtask

  initial begin
    rst = 0; clk_en = 1; zero = 1; op_result = 14'sd55; alg = 3'd7;
    s1_enters = 1; s2_enters = 0; s3_enters = 0; s4_enters = 0;
    pan_l = 1; pan_r = 1; ovf_clr = 0; mute_m = '0; mute_s = '0;
    alg_exp = '{8, 8, 8, 8, 12, 14, 14, 15};
    fill_tab(14'sd100, 3'd7);

    // Reset wins over clk_en and zero.
    repeat (3) @(posedge clk);
    #1;
    check("rst_left_m", snd_left_m, 0);
    check("rst_right_m", snd_right_m, 0);
    check("rst_sample_m", sample_m, 0);
    check("rst_ovf_m", ovf_m, 0);
    check("rst_left_s", snd_left_s, 0);
    check("rst_sample_s", sample_s, 0);
    rst = 1; clk_en = 0; zero = 0;
    @(posedge clk); #1;

    // Test 1: mono pass-through, 3 ch x 4 ops x 100.
    zero_slot(3);
    check("first_zero_suppressed", sample_m, 0);
    run_frame(3);
    check("t1_pulses_in_frame", pulses, 0);
    zero_slot(3);
    check("t1_sample", sample_m, 1);
    check("t1_left", snd_left_m, 1200);
    check("t1_right", snd_right_m, 1200);
    check("t1_ovf", ovf_m, 0);
    run_frame(3);
    check("t1_pulses_in_frame2", pulses, 0);
    zero_slot(3);
    check("t1_left2", snd_left_m, 1200);
    check("t1_sample2", sample_m, 1);

    // Test 5: random clk_en gaps give identical results.
    gaps_on = 1;
    run_frame(3);
    check("t5_pulses_in_frame", pulses, 0);
    zero_slot(3);
    check("t5_sample", sample_m, 1);
    check("t5_left", snd_left_m, 1200);
    check("t5_right", snd_right_m, 1200);
    clk_en = 0;
    @(posedge clk); #1;
    check("t5_pulse_width", sample_m, 0);
    check("t5_hold_left", snd_left_m, 1200);
    gaps_on = 0;

    // Test 6: reset at slot 7 discards the frame and suppresses the next sample.
    for (int i = 1; i < 7; i++) slot_at(3, i);
    rst = 0; clk_en = 1;
    @(posedge clk); #1;
    rst = 1;
    check("t6_rst_left", snd_left_m, 0);
    check("t6_rst_right", snd_right_m, 0);
    check("t6_rst_sample", sample_m, 0);
    for (int i = 8; i < 12; i++) slot_at(3, i);
    zero_slot(3);
    check("t6_no_sample", sample_m, 0);
    check("t6_left_zero", snd_left_m, 0);
    run_frame(3);
    zero_slot(3);
    check("t6_sample", sample_m, 1);
    check("t6_left", snd_left_m, 1200);
    check("t6_right", snd_right_m, 1200);

    // Test 2: algorithm decode on ch0 of the stereo instance.
    opened = 0;
    fill_tab(14'sd0, 3'd7);
    op_tab[0][0] = 14'sd1; op_tab[1][0] = 14'sd2;
    op_tab[2][0] = 14'sd4; op_tab[3][0] = 14'sd8;
    for (int a = 0; a < 8; a++) begin
      alg_tab[0] = 3'(a);
      measure(6);
      check($sformatf("t2_alg%0d_left", a), snd_left_s, alg_exp[a]);
      check($sformatf("t2_alg%0d_right", a), snd_right_s, alg_exp[a]);
    end
    check("t2_sample", sample_s, 1);

    // Test 3: pan and mute, 500 per channel on S4 with alg0.
    fill_tab(14'sd0, 3'd0);
    op_tab[3][0] = 14'sd500; op_tab[3][1] = 14'sd500; op_tab[3][2] = 14'sd500;
    pl_tab[0] = 1; pr_tab[0] = 0;
    pl_tab[1] = 0; pr_tab[1] = 1;
    pl_tab[2] = 1; pr_tab[2] = 1;
    mute_s = 6'b000100;
    measure(6);
    check("t3_muted_left", snd_left_s, 500);
    check("t3_muted_right", snd_right_s, 500);
    mute_s = 6'b000000;
    measure(6);
    check("t3_left", snd_left_s, 1000);
    check("t3_right", snd_right_s, 1000);

    // Test 4: saturation and the sticky overflow flag.
    fill_tab(14'sd8191, 3'd7);
    measure(6);
    check("t4_pos_left", snd_left_s, 32767);
    check("t4_pos_right", snd_right_s, 32767);
    check("t4_pos_ovf", ovf_s, 1);
    fill_tab(-14'sd8192, 3'd7);
    measure(6);
    check("t4_neg_left", snd_left_s, -32768);
    check("t4_neg_right", snd_right_s, -32768);
    fill_tab(14'sd0, 3'd7);
    measure(6);
    check("t4_zero_left", snd_left_s, 0);
    check("t4_ovf_sticky", ovf_s, 1);
    check("t4_mono_ovf", ovf_m === 1'bx ? 1 : 0, 0);
    ovf_clr = 1; clk_en = 0;
    @(posedge clk); #1;
    ovf_clr = 0;
    check("t4_ovf_clr", ovf_s, 0);
    fill_tab(14'sd8191, 3'd7);
    run_frame(6);
    ovf_clr = 1;
    zero_slot(6);
    ovf_clr = 0;
    check("t4_set_wins_ovf", ovf_s, 1);
    check("t4_set_wins_left", snd_left_s, 32767);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
